// File: rtl/score_bcd_sequencer.sv
// Score to 6-digit BCD converter: a 20-step double-dabble engine under a small FSM, no backpressure.
// Request (start / score change / pending) in IDLE -> done and new digits 22 cycles later; requests while busy queue one follow-up.
module score_bcd_sequencer #(
  parameter int NUM_DIGITS = 6,
  parameter int SHIFT_BITS = 20,
  parameter int MAX_SCORE  = 999999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] score,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit4,
  output logic [3:0]  digit5
);

  localparam int                  BCD_BITS = 4 * NUM_DIGITS;
  localparam int                  CNT_W    = $clog2(SHIFT_BITS);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SHIFT_BITS - 1);
  localparam logic [31:0]         MAX32    = 32'(MAX_SCORE);
  localparam logic [SHIFT_BITS-1:0] MAX_CAP = SHIFT_BITS'(MAX_SCORE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [31:0]             last_score;
  logic                    pending;
  logic                    ovf_next;
  logic [SHIFT_BITS-1:0]   bin, bin_shf, cap;
  logic [BCD_BITS-1:0]     bcd, bcd_adj, bcd_shf;
  logic [BCD_BITS-1:0]     disp;
  logic [CNT_W-1:0]        cnt;
  logic                    changed;
  logic                    request;
  logic                    over_max;

  assign changed  = (score != last_score);
  assign request  = start | changed | pending;
  assign over_max = (score > MAX32);
  assign cap      = over_max ? MAX_CAP : score[SHIFT_BITS-1:0];

  // One double-dabble step: correct nibbles >= 5, then shift the whole {bcd, bin} pair.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    {bcd_shf, bin_shf} = {bcd_adj, bin} << 1;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        busy      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_score <= '0;
      pending    <= 1'b0;
      ovf_next   <= 1'b0;
      overflow   <= 1'b0;
      bin        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      disp       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (request) begin
            pending <= 1'b0;
          end
        end
        LOAD: begin
          // The score sampled here is the one converted, so only start can queue another pass.
          last_score <= score;
          bin        <= cap;
          bcd        <= '0;
          cnt        <= '0;
          ovf_next   <= over_max;
          if (start) begin
            pending <= 1'b1;
          end
        end
        SHIFT: begin
          bcd <= bcd_shf;
          bin <= bin_shf;
          cnt <= cnt + 1'b1;
          if (start || changed) begin
            pending <= 1'b1;
          end
          // Publish on the last step so digits and done appear together in DONE.
          if (cnt == CNT_LAST) begin
            disp     <= bcd_shf;
            overflow <= ovf_next;
          end
        end
        DONE: begin
          if (start || changed) begin
            pending <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign digit0 = disp[3:0];
  assign digit1 = disp[7:4];
  assign digit2 = disp[11:8];
  assign digit3 = disp[15:12];
  assign digit4 = disp[19:16];
  assign digit5 = disp[23:20];

endmodule

// File: tb/tb_score_bcd_sequencer.sv
// Scoreboard bench for score_bcd_sequencer: expected digits/overflow/done cycle queued at stimulus, popped on done.
module tb_score_bcd_sequencer;

  typedef struct packed {
    logic [23:0] dig;
    logic        ovf;
    logic [31:0] due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] score;
  logic        start;
  logic        busy, done, overflow;
  logic [3:0]  digit0, digit1, digit2, digit3, digit4, digit5;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];

  score_bcd_sequencer dut (
    .clock    (clock),
    .reset    (reset),
    .score    (score),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .digit0   (digit0),
    .digit1   (digit1),
    .digit2   (digit2),
    .digit3   (digit3),
    .digit4   (digit4),
    .digit5   (digit5)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] to_bcd(input logic [31:0] s);
    logic [31:0] v;
    logic [23:0] r;
    v = (s > 32'd999999) ? 32'd999999 : s;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic expect_conv(input logic [31:0] s, input int due);
    exp_t e;
    e.dig = to_bcd(s);
    e.ovf = (s > 32'd999999);
    e.due = 32'(due);
    sb.push_back(e);
  endtask

  function automatic logic [23:0] shown();
    return {digit5, digit4, digit3, digit2, digit1, digit0};
  endfunction

  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("digits", 32'(shown()), 32'(e.dig));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("done_cycle", 32'(cyc), e.due);
      end
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic convert(input logic [31:0] s);
    score = s;
    expect_conv(s, cyc + 22);
    drain(80);
  endtask

  initial begin
    reset = 1'b1;
    score = '0;
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_digits", 32'(shown()), 32'd0);
    repeat (50) @(negedge clock);
    chk("idle_busy", 32'(busy), 32'd0);

    // Latency and busy window around a single conversion.
    score = 32'd123456;
    expect_conv(score, cyc + 22);
    @(negedge clock);
    chk("busy_c1", 32'(busy), 32'd1);
    repeat (20) @(negedge clock);
    chk("busy_c21", 32'(busy), 32'd1);
    @(negedge clock);
    chk("busy_c22", 32'(busy), 32'd0);
    drain(40);
    repeat (5) @(negedge clock);
    chk("digits_hold", 32'(shown()), 32'h123456);

    convert(32'd999999);
    convert(32'd1000000);
    convert(32'hFFFFFFFF);
    convert(32'd7);
    convert(32'd500000);
    convert(32'd80808);

    // Changes while busy collapse into one follow-up using the latest score.
    score = 32'd42;
    expect_conv(32'd42, cyc + 22);
    expect_conv(32'd90, cyc + 45);
    repeat (10) @(negedge clock);
    score = 32'd58;
    repeat (5) @(negedge clock);
    score = 32'd90;
    drain(100);

    // Reset in the middle of a conversion aborts it.
    score = 32'd654321;
    repeat (12) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    chk("abort_digits", 32'(shown()), 32'd0);
    reset = 1'b0;
    expect_conv(32'd654321, cyc + 22);
    drain(60);

    // Forced conversions with an unchanged score; a start while busy queues exactly one more.
    convert(32'd555);
    start = 1'b1;
    expect_conv(32'd555, cyc + 22);
    expect_conv(32'd555, cyc + 45);
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    drain(100);

    // Start together with a score change in IDLE yields a single conversion.
    score = 32'd321;
    start = 1'b1;
    expect_conv(32'd321, cyc + 22);
    @(negedge clock);
    start = 1'b0;
    drain(60);

    for (int i = 0; i < 4; i++) begin
      convert($urandom_range(0, 1200000));
    end

    repeat (60) @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_bcd_sequencer.md
Name: score_bcd_sequencer

Overview:
Sequential score-to-decimal converter for the HUD score display. It replaces wide combinational divide/modulo chains with a 20-step shift-and-add-3 (double-dabble) engine run by a small FSM. A conversion starts on an explicit start pulse or automatically when the score changes. Display digits are registered and only update when a conversion completes, so the display never shows partial values.

Parameters:
NUM_DIGITS, 6, number of BCD digits produced; fixed at 6 for this display.
SHIFT_BITS, 20, binary width fed to the engine; 2^20 > 999999.
MAX_SCORE, 999999, largest displayable value; larger scores clamp to this value.

Ports:
clock  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
score  input  32  unsigned game score; may change on any cycle.
start  input  1  one-cycle request to force a conversion.
busy  output  1  high while in the LOAD or SHIFT state.
done  output  1  one-cycle pulse when the digit outputs have just updated.
overflow  output  1  high if the last converted score exceeded MAX_SCORE.
digit0..digit5  output  4 each  BCD digits; digit0 is the least significant.

Behaviour:
- Reset values: state=IDLE; busy=0, done=0, overflow=0; all digits=0; last_score=0; pending=0; shift and BCD registers=0.
- Request condition: start, OR score != last_score, OR pending.
- pending: set by start or by a score change (score != captured value) while in LOAD, SHIFT or DONE. Cleared on entry to LOAD.
- State IDLE: if the request condition holds, go to LOAD on the next cycle.
- State LOAD (1 cycle):
  - cap = (score > MAX_SCORE) ? MAX_SCORE : score[19:0].
  - Set ovf_next = (score > MAX_SCORE); the comparison is a full 32-bit unsigned compare.
  - Load last_score <= score (the raw value). Load the shift register with cap. Clear the 24-bit BCD accumulator and the step counter.
- State SHIFT (exactly SHIFT_BITS = 20 cycles), each cycle:
  - Add 3 to every BCD nibble that is >= 5.
  - Shift {bcd, bin} left by 1.
  - Increment the counter. On count 19, go to DONE.
- State DONE (1 cycle):
  - digitN <= bcd[4N+3:4N]; overflow <= ovf_next; done=1.
  - Next state is IDLE.
- Latency: a request sampled in IDLE at cycle 0 gives LOAD at cycle 1, SHIFT at cycles 2–21, and done=1 with new digits visible at cycle 22. Minimum spacing between done pulses is 23 cycles.
- Digits and overflow hold their values between done pulses. Nibble values are always 0–9.
- Simultaneous events:
  - start and a score change in the same IDLE cycle produce one conversion.
  - start while busy is not dropped; it causes one further conversion after the current one.
  - Multiple changes while busy collapse into one follow-up conversion, which uses the score present at that LOAD.
- Reset mid-conversion: aborts immediately. Outputs return to their reset values; no done pulse is issued.
  - After reset is released, a nonzero score triggers a conversion through change detection, because last_score = 0.
- Score = 0 after reset: no automatic conversion (score equals last_score). Digits are already 0.

Test Plan:
- Reset with score=0, no start for 50 cycles -> done never pulses; digits all 0; busy=0.
- score=123456 held from cycle 0 (IDLE) -> busy at cycle 1; done=1 only at cycle 22; digit5..digit0 = 1,2,3,4,5,6; overflow=0.
- Boundary: score=999999 -> digits 9,9,9,9,9,9 with overflow=0. Then score=1000000 -> digits 9,9,9,9,9,9 with overflow=1. Then score=32'hFFFFFFFF -> same digits, overflow=1. Then score=7 -> digits 0,0,0,0,0,7 with overflow=0.
- score=42, then changed to 58 on cycle 10 while busy, then to 90 on cycle 15:
  - First done at cycle 22 shows 000042.
  - Exactly one further conversion follows, with done at cycle 45, showing 000090.
- Reset asserted at cycle 12 of a conversion of 654321 -> all outputs are 0 the next cycle; no done. Score held at 654321 after release -> done 22 cycles after the first IDLE cycle, showing 654321.
- start pulsed with score unchanged (555) -> one conversion; done at +22; digits 000555. A start pulsed during that conversion -> exactly one extra done pulse.
